// File: rtl/key_debounce_sched.sv
// Four-key debouncer with one shared counter serviced round-robin; emits one event pulse per debounced change.
// Optional macro KEY_RELEASE_FLAG_EN: when defined, releases also pulse key_flag (key_press=0).
module key_debounce_sched #(
  parameter logic [19:0] CNT_MAX = 20'd999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_in,
  output logic       key_flag,
  output logic [1:0] key_id,
  output logic       key_press,
  output logic [3:0] key_state
);

  typedef enum logic {SCAN = 1'b0, DEB = 1'b1} state_e;

  localparam logic [19:0] CNT_LAST = CNT_MAX - 20'd1;

  state_e      state_q, state_d;
  logic [3:0]  sync1_q, key_sync_q;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  key_state_q, key_state_d;
  logic        flag_q, flag_d;
  logic [1:0]  id_q, id_d;
  logic        press_q, press_d;
  logic        hit;
  logic [1:0]  hit_idx;

  // Synchronizers reset to "released" so no event fires out of reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q    <= 4'hF;
      key_sync_q <= 4'hF;
    end else begin
      sync1_q    <= key_in;
      key_sync_q <= sync1_q;
    end
  end

  // First key (from rr_ptr upward, wrapping) whose synced level differs from its debounced level.
  always_comb begin
    hit     = 1'b0;
    hit_idx = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!hit && (key_sync_q[rr_ptr_q + 2'(k)] != key_state_q[rr_ptr_q + 2'(k)])) begin
        hit     = 1'b1;
        hit_idx = rr_ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    key_state_d = key_state_q;
    flag_d      = 1'b0;
    id_d        = id_q;
    press_d     = press_q;
    case (state_q)
      SCAN: begin
        if (hit) begin
          sel_d   = hit_idx;
          cnt_d   = '0;
          state_d = DEB;
        end
      end
      DEB: begin
        if (key_sync_q[sel_q] == key_state_q[sel_q]) begin
          rr_ptr_d = sel_q + 2'd1;
          cnt_d    = '0;
          state_d  = SCAN;
        end else if (cnt_q == CNT_LAST) begin
          key_state_d[sel_q] = ~key_state_q[sel_q];
          rr_ptr_d           = sel_q + 2'd1;
          cnt_d              = '0;
          state_d            = SCAN;
`ifdef KEY_RELEASE_FLAG_EN
          flag_d  = 1'b1;
          id_d    = sel_q;
          press_d = ~key_sync_q[sel_q];
`else
          // Releases update key_state silently; id/press keep the last press.
          if (!key_sync_q[sel_q]) begin
            flag_d  = 1'b1;
            id_d    = sel_q;
            press_d = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      key_state_q <= 4'hF;
      flag_q      <= 1'b0;
      id_q        <= '0;
      press_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      key_state_q <= key_state_d;
      flag_q      <= flag_d;
      id_q        <= id_d;
      press_q     <= press_d;
    end
  end

  assign key_flag  = flag_q;
  assign key_id    = id_q;
  assign key_press = press_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_key_debounce_sched.sv
// Scoreboard bench for key_debounce_sched: expected events (id, type, arrival cycle) queued at stimulus time.
module tb_key_debounce_sched;
  localparam int CNT_MAX = 24;
  // Cycle of the drive edge to the cycle key_flag is visible: 2 sync + 1 detect + CNT_MAX in DEB.
  localparam int LAT     = CNT_MAX + 3;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_in    = 4'hF;
  logic       key_flag;
  logic [1:0] key_id;
  logic       key_press;
  logic [3:0] key_state;

  typedef struct {
    logic [1:0]  id;
    logic        press;
    int unsigned cyc;
  } ev_t;

  ev_t         sb[$];
  ev_t         e;
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;

  key_debounce_sched #(.CNT_MAX(20'(CNT_MAX))) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_id   (key_id),
    .key_press(key_press),
    .key_state(key_state)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic press, input int unsigned c);
    ev_t t;
    t.id = id; t.press = press; t.cyc = c;
    sb.push_back(t);
  endtask

  task automatic set_keys(input logic [3:0] v);
    @(posedge sys_clk); #1;
    key_in = v;
  endtask

  task automatic set_key(input int i, input logic v);
    @(posedge sys_clk); #1;
    key_in[i] = v;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge sys_clk);
      t++;
    end
    chk(tag, sb.size(), 0);
    repeat (5) @(posedge sys_clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_flag", {31'b0, key_flag}, 0);
    chk("rst_id", {30'b0, key_id}, 0);
    chk("rst_press", {31'b0, key_press}, 0);
    chk("rst_state", {28'b0, key_state}, 4'hF);
  endtask

  // Every flag must match the head of the scoreboard, including its arrival cycle.
  always @(negedge sys_clk) begin
    if (sys_rst_n && key_flag) begin
      if (sb.size() == 0) begin
        chk("spurious_flag", {31'b0, key_flag}, 0);
      end else begin
        e = sb.pop_front();
        chk("ev_id", {30'b0, key_id}, {30'b0, e.id});
        chk("ev_press", {31'b0, key_press}, {31'b0, e.press});
        chk("ev_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    logic        lvl;
    int          t, r;
    int unsigned s, m;

    // Reset values, then quiet idle with all keys released.
    repeat (3) @(posedge sys_clk);
    #2 chk_reset_vals();
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    repeat (40) @(posedge sys_clk);
    chk("idle_state", {28'b0, key_state}, 4'hF);

    // Clean press on key 0.
    set_keys(4'b1110);
    push(2'd0, 1'b1, cyc + LAT);
    drain("drain_press0");
    chk("state_press0", {28'b0, key_state}, 4'hE);

    // Bounce on key 1: runs of 1..5 cycles (shorter than the window), then settle low.
    lvl = 1'b1; t = 0; s = 0;
    while (t < 30) begin
      lvl = ~lvl;
      r = $urandom_range(1, 5);
      set_key(1, lvl);
      if (!lvl) s = cyc;
      repeat (r - 1) @(posedge sys_clk);
      t += r;
    end
    if (lvl) begin
      set_key(1, 1'b0);
      s = cyc;
    end
    push(2'd1, 1'b1, s + LAT);
    drain("drain_bounce1");
    chk("state_bounce1", {28'b0, key_state}, 4'hC);

    // Release key 0.
    set_key(0, 1'b1);
`ifdef KEY_RELEASE_FLAG_EN
    push(2'd0, 1'b0, cyc + LAT);
`endif
    repeat (LAT + 5) @(posedge sys_clk);
    drain("drain_rel0");
    chk("state_rel0", {28'b0, key_state}, 4'hD);
`ifdef KEY_RELEASE_FLAG_EN
    chk("hold_id_rel0", {30'b0, key_id}, 0);
`else
    chk("hold_id_rel0", {30'b0, key_id}, 1);
    chk("hold_press_rel0", {31'b0, key_press}, 1);
`endif

    // Release key 1, then reset so rr_ptr restarts at 0.
    set_key(1, 1'b1);
`ifdef KEY_RELEASE_FLAG_EN
    push(2'd1, 1'b0, cyc + LAT);
`endif
    repeat (LAT + 5) @(posedge sys_clk);
    drain("drain_rel1");
    @(negedge sys_clk) sys_rst_n = 1'b0;
    @(negedge sys_clk) sys_rst_n = 1'b1;

    // Keys 2 and 3 pressed together: key 2 first, key 3 one full window later.
    set_keys(4'b0011);
    push(2'd2, 1'b1, cyc + LAT);
    push(2'd3, 1'b1, cyc + LAT + CNT_MAX + 1);
    drain("drain_simul");
    chk("state_simul", {28'b0, key_state}, 4'h3);

    // Release both; rr_ptr wrapped to 0 so key 2 is serviced first again.
    set_keys(4'b1111);
`ifdef KEY_RELEASE_FLAG_EN
    push(2'd2, 1'b0, cyc + LAT);
    push(2'd3, 1'b0, cyc + LAT + CNT_MAX + 1);
`endif
    repeat (2 * LAT + 5) @(posedge sys_clk);
    drain("drain_rel23");
    chk("state_rel23", {28'b0, key_state}, 4'hF);

    // Reset while key 0 is mid-window (cnt = 10), key still held.
    set_key(0, 1'b0);
    repeat (13) @(posedge sys_clk);
    #5 sys_rst_n = 1'b0;
    #2 chk_reset_vals();
    @(negedge sys_clk) sys_rst_n = 1'b1;
    m = cyc;
    push(2'd0, 1'b1, m + LAT);
    drain("drain_rst_deb");
    chk("state_rst_deb", {28'b0, key_state}, 4'hE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
